checker_input_ctrl: RTL and testbench

- Game-input sequencer that drives the board renderer's cursor_loc, select_loc and legal_move inputs from five push buttons.
- Debounces the buttons, moves the cursor, selects pieces of the side to move, and computes the legal-move list over four cycles.
- Issues a move request to the board-state logic with a req/ack handshake, then toggles the turn.

---
 rtl/checker_pkg.sv | 13 +
 rtl/btn_debounce.sv | 29 ++
 rtl/checker_input_ctrl.sv | 151 +++++++++++++++
 tb/tb_checker_input_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// checker_pkg: shared cell fields, slot layout, FSM states and board access helper
package checker_pkg;
  localparam int OCC = 2;
  localparam int RED = 1;
  localparam int KING = 0;
  localparam int SLOT_W = 7;
  localparam int SLOTS = 4;
  localparam logic [5:0] IDLE_SEL = 6'd1;
  typedef enum logic [1:0] {IDLE, CALC, SELECTED, COMMIT} state_t;
  function automatic logic cell_bit(input logic [191:0] b, input logic [5:0] i, input int f);
    return b[3*int'(i)+f];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl, flip;
  logic [CW-1:0] cnt;
  // cnt counts consecutive samples that disagree with the accepted level
  assign flip = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      cnt <= (s2 == lvl || flip) ? '0 : cnt + CW'(1);
      lvl <= flip ? s2 : lvl;
      press <= flip & s2;
    end
endmodule

// File: rtl/checker_input_ctrl.sv
// checker_input_ctrl: button-driven cursor, piece selection, legal-move search and move handshake
module checker_input_ctrl
  import checker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_sel,
  input  logic [191:0] serialized_board,
  input  logic         move_ack,
  output logic [5:0]   cursor_loc,
  output logic [5:0]   select_loc,
  output logic [27:0]  legal_move,
  output logic         move_req,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to,
  output logic         move_jump,
  output logic         turn
);
  logic [4:0] raw, prs;
  state_t state, nxt_state;
  logic [1:0] dir, nxt_dir;
  logic [3:0] jmp_flags, nxt_jmp_flags;
  logic [5:0] nxt_cursor, nxt_select, nxt_from, nxt_to;
  logic [27:0] nxt_legal;
  logic nxt_req, nxt_jump, nxt_turn;
  logic [3:0] nx, ny, jx, jy;
  logic [2:0] cx, cy;
  logic own, slot_ok, n_on, j_on, step, cap, hit, hit_jump;
  logic [6:0] slot_val;
  assign raw = {btn_sel, btn_up, btn_down, btn_left, btn_right};
  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .btn(raw[i]),
      .press(prs[i])
    );
  end
  assign {cx, cy} = cursor_loc;
  assign own = cell_bit(serialized_board, cursor_loc, OCC) &&
               (cell_bit(serialized_board, cursor_loc, RED) == turn);
  // 4-bit coordinates: bit 3 set means the step fell off the board
  assign nx = {1'b0, select_loc[5:3]} + (dir[0] ? 4'd1 : 4'hF);
  assign ny = {1'b0, select_loc[2:0]} + ((turn ^ dir[1]) ? 4'hF : 4'd1);
  assign jx = {1'b0, select_loc[5:3]} + (dir[0] ? 4'd2 : 4'hE);
  assign jy = {1'b0, select_loc[2:0]} + ((turn ^ dir[1]) ? 4'hE : 4'd2);
  assign n_on = !nx[3] && !ny[3];
  assign j_on = !jx[3] && !jy[3];
  assign slot_ok = !dir[1] || cell_bit(serialized_board, select_loc, KING);
  assign step = slot_ok && n_on && !cell_bit(serialized_board, {nx[2:0], ny[2:0]}, OCC);
  assign cap = slot_ok && n_on && j_on &&
               cell_bit(serialized_board, {nx[2:0], ny[2:0]}, OCC) &&
               (cell_bit(serialized_board, {nx[2:0], ny[2:0]}, RED) != turn) &&
               !cell_bit(serialized_board, {jx[2:0], jy[2:0]}, OCC);
  assign slot_val = step ? {1'b1, nx[2:0], ny[2:0]} : cap ? {1'b1, jx[2:0], jy[2:0]} : 7'd0;
  always_comb begin
    hit = 1'b0;
    hit_jump = 1'b0;
    for (int k = 0; k < SLOTS; k++)
      if (legal_move[SLOT_W*k+6] && legal_move[SLOT_W*k +: 6] == cursor_loc) begin
        hit = 1'b1;
        hit_jump = jmp_flags[k];
      end
  end
  always_comb begin
    nxt_state = state;
    nxt_dir = dir;
    nxt_jmp_flags = jmp_flags;
    nxt_cursor = cursor_loc;
    nxt_select = select_loc;
    nxt_legal = legal_move;
    nxt_req = move_req;
    nxt_from = move_from;
    nxt_to = move_to;
    nxt_jump = move_jump;
    nxt_turn = turn;
    if ((state == IDLE || state == SELECTED) && !prs[4])
      nxt_cursor = prs[3] ? {cx, cy + 3'd1} : prs[2] ? {cx, cy - 3'd1} :
                   prs[1] ? {cx - 3'd1, cy} : prs[0] ? {cx + 3'd1, cy} : cursor_loc;
    case (state)
      IDLE: if (prs[4] && own) begin
        nxt_select = cursor_loc;
        nxt_dir = 2'd0;
        nxt_state = CALC;
      end
      CALC: begin
        nxt_legal[SLOT_W*dir +: SLOT_W] = slot_val;
        nxt_jmp_flags[dir] = cap;
        nxt_dir = dir + 2'd1;
        nxt_state = (dir == 2'd3) ? SELECTED : CALC;
      end
      SELECTED: if (prs[4]) begin
        if (cursor_loc == select_loc) begin
          nxt_select = IDLE_SEL;
          nxt_legal = '0;
          nxt_state = IDLE;
        end else if (hit) begin
          nxt_from = select_loc;
          nxt_to = cursor_loc;
          nxt_jump = hit_jump;
          nxt_req = 1'b1;
          nxt_state = COMMIT;
        end else if (own) begin
          nxt_select = cursor_loc;
          nxt_dir = 2'd0;
          nxt_state = CALC;
        end
      end
      COMMIT: if (move_ack) begin
        nxt_req = 1'b0;
        nxt_legal = '0;
        nxt_select = IDLE_SEL;
        nxt_turn = ~turn;
        nxt_state = IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      dir <= '0;
      jmp_flags <= '0;
      cursor_loc <= '0;
      select_loc <= IDLE_SEL;
      legal_move <= '0;
      move_req <= 1'b0;
      move_from <= '0;
      move_to <= '0;
      move_jump <= 1'b0;
      turn <= 1'b0;
    end else begin
      state <= nxt_state;
      dir <= nxt_dir;
      jmp_flags <= nxt_jmp_flags;
      cursor_loc <= nxt_cursor;
      select_loc <= nxt_select;
      legal_move <= nxt_legal;
      move_req <= nxt_req;
      move_from <= nxt_from;
      move_to <= nxt_to;
      move_jump <= nxt_jump;
      turn <= nxt_turn;
    end
endmodule

// File: tb/tb_checker_input_ctrl.sv
// tb_checker_input_ctrl: scripted vectors, corner sequences and randomized play against a game model
module tb_checker_input_ctrl;
  localparam logic [4:0] B_SEL = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100, B_LF = 5'b00010, B_RT = 5'b00001;
  typedef struct {
    logic [4:0]  btn;
    logic [5:0]  cur;
    logic [5:0]  sel;
    logic [27:0] legal;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [191:0] serialized_board = '0;
  logic move_ack = 1'b0;
  logic [5:0] cursor_loc, select_loc, move_from, move_to;
  logic [27:0] legal_move;
  logic move_req, move_jump, turn;
  int n_chk = 0, n_fail = 0;
  logic [2:0] bd [64];
  logic [5:0] m_cur, m_sel, m_from, m_to;
  logic [27:0] m_legal;
  logic [3:0] m_jf;
  logic m_turn, m_req, m_jump;
  int m_mode;
  vec_t vecs [21];

  always #5 clk = ~clk;

  checker_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel),
    .serialized_board(serialized_board), .move_ack(move_ack),
    .cursor_loc(cursor_loc), .select_loc(select_loc), .legal_move(legal_move),
    .move_req(move_req), .move_from(move_from), .move_to(move_to), .move_jump(move_jump), .turn(turn)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] ser();
    logic [191:0] b;
    for (int i = 0; i < 64; i++) b[3*i +: 3] = bd[i];
    return b;
  endfunction

  task automatic press(input logic [4:0] m);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = m;
    repeat (8) @(negedge clk);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    move_ack = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_cur = 0; m_sel = 6'd1; m_legal = 0; m_jf = 0;
    m_turn = 0; m_req = 0; m_from = 0; m_to = 0; m_jump = 0; m_mode = 0;
  endtask

  task automatic ref_moves(input int x, input int y, output logic [27:0] lg, output logic [3:0] jf);
    int fwd, dx, dy, nx, ny, jx, jy;
    logic [2:0] c;
    lg = 0;
    jf = 0;
    fwd = m_turn ? -1 : 1;
    for (int k = 0; k < 4; k++) begin
      dx = (k % 2 == 1) ? 1 : -1;
      dy = (k < 2) ? fwd : -fwd;
      nx = x + dx; ny = y + dy; jx = x + 2*dx; jy = y + 2*dy;
      if (k >= 2 && !bd[x*8+y][0]) continue;
      if (nx < 0 || nx > 7 || ny < 0 || ny > 7) continue;
      c = bd[nx*8+ny];
      if (!c[2]) lg[7*k +: 7] = {1'b1, 3'(nx), 3'(ny)};
      else if (c[1] != m_turn && jx >= 0 && jx < 8 && jy >= 0 && jy < 8 && !bd[jx*8+jy][2]) begin
        lg[7*k +: 7] = {1'b1, 3'(jx), 3'(jy)};
        jf[k] = 1'b1;
      end
    end
  endtask

  task automatic model_press(input logic [4:0] m);
    int x, y, hitk;
    logic own;
    x = int'(m_cur[5:3]);
    y = int'(m_cur[2:0]);
    own = bd[m_cur][2] && (bd[m_cur][1] == m_turn);
    hitk = -1;
    if (m_mode == 2) return;
    if (m[4]) begin
      for (int k = 0; k < 4; k++)
        if (m_legal[7*k+6] && m_legal[7*k +: 6] == m_cur) hitk = k;
      if (m_mode == 0) begin
        if (own) begin m_sel = m_cur; ref_moves(x, y, m_legal, m_jf); m_mode = 1; end
      end else if (m_cur == m_sel) begin
        m_sel = 6'd1; m_legal = 0; m_mode = 0;
      end else if (hitk >= 0) begin
        m_from = m_sel; m_to = m_cur; m_jump = m_jf[hitk]; m_req = 1; m_mode = 2;
      end else if (own) begin
        m_sel = m_cur; ref_moves(x, y, m_legal, m_jf);
      end
    end else begin
      if (m[3]) y = (y + 1) % 8;
      else if (m[2]) y = (y + 7) % 8;
      else if (m[1]) x = (x + 7) % 8;
      else if (m[0]) x = (x + 1) % 8;
      m_cur = {3'(x), 3'(y)};
    end
  endtask

  task automatic cmp_all(input string t);
    chk({t, " cursor"}, 32'(cursor_loc), 32'(m_cur));
    chk({t, " select"}, 32'(select_loc), 32'(m_sel));
    chk({t, " legal"}, 32'(legal_move), 32'(m_legal));
    chk({t, " req"}, 32'(move_req), 32'(m_req));
    chk({t, " turn"}, 32'(turn), 32'(m_turn));
  endtask

  task automatic finish_move();
    bd[m_to] = bd[m_from];
    bd[m_from] = 3'b0;
    if (m_jump) bd[(int'(m_from) + int'(m_to)) / 2] = 3'b0;
    m_req = 0; m_legal = 0; m_sel = 6'd1; m_turn = ~m_turn; m_mode = 0;
    serialized_board = ser();
  endtask

  initial begin
    logic [4:0] mk;
    vecs = '{
      '{B_LF, 6'd56, 6'd1, 28'h0}, '{B_RT, 6'd0, 6'd1, 28'h0}, '{B_DN, 6'd7, 6'd1, 28'h0},
      '{B_UP, 6'd0, 6'd1, 28'h0}, '{B_RT, 6'd8, 6'd1, 28'h0}, '{B_RT, 6'd16, 6'd1, 28'h0},
      '{B_UP, 6'd17, 6'd1, 28'h0}, '{B_UP, 6'd18, 6'd1, 28'h0}, '{B_SEL, 6'd18, 6'd18, 28'h000324B},
      '{B_SEL, 6'd18, 6'd1, 28'h0}, '{B_UP, 6'd19, 6'd1, 28'h0}, '{B_SEL, 6'd19, 6'd1, 28'h0},
      '{B_RT, 6'd27, 6'd1, 28'h0}, '{B_SEL, 6'd27, 6'd1, 28'h0}, '{B_LF, 6'd19, 6'd1, 28'h0},
      '{B_DN, 6'd18, 6'd1, 28'h0}, '{B_SEL | B_UP, 6'd18, 6'd18, 28'h000324B},
      '{B_UP, 6'd19, 6'd18, 28'h000324B}, '{B_UP, 6'd20, 6'd18, 28'h000324B},
      '{B_RT, 6'd28, 6'd18, 28'h000324B}, '{B_RT, 6'd36, 6'd18, 28'h000324B}
    };
    for (int i = 0; i < 64; i++) bd[i] = 3'b0;
    bd[18] = 3'b100;
    bd[27] = 3'b110;
    serialized_board = ser();
    @(negedge clk);
    chk("reset cursor", 32'(cursor_loc), 32'd0);
    chk("reset select", 32'(select_loc), 32'd1);
    chk("reset legal", 32'(legal_move), 32'd0);
    chk("reset req", 32'(move_req), 32'd0);
    chk("reset from", 32'(move_from), 32'd0);
    chk("reset to", 32'(move_to), 32'd0);
    chk("reset jump", 32'(move_jump), 32'd0);
    chk("reset turn", 32'(turn), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch cursor", 32'(cursor_loc), 32'd0);
    for (int i = 0; i < 21; i++) begin
      press(vecs[i].btn);
      chk($sformatf("vec%0d cursor", i), 32'(cursor_loc), 32'(vecs[i].cur));
      chk($sformatf("vec%0d select", i), 32'(select_loc), 32'(vecs[i].sel));
      chk($sformatf("vec%0d legal", i), 32'(legal_move), 32'(vecs[i].legal));
    end
    press(B_SEL);
    chk("commit req", 32'(move_req), 32'd1);
    chk("commit from", 32'(move_from), 32'd18);
    chk("commit to", 32'(move_to), 32'd36);
    chk("commit jump", 32'(move_jump), 32'd1);
    press(B_LF);
    chk("commit ignores press", 32'(cursor_loc), 32'd36);
    repeat (2) @(negedge clk);
    chk("commit req held", 32'(move_req), 32'd1);
    move_ack = 1'b1;
    @(negedge clk);
    move_ack = 1'b0;
    chk("ack req", 32'(move_req), 32'd0);
    chk("ack turn", 32'(turn), 32'd1);
    chk("ack legal", 32'(legal_move), 32'd0);
    chk("ack select", 32'(select_loc), 32'd1);
    do_reset();
    press(B_RT); press(B_RT); press(B_UP); press(B_UP); press(B_SEL);
    press(B_UP); press(B_UP); press(B_RT); press(B_RT); press(B_SEL);
    chk("second commit req", 32'(move_req), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async reset req", 32'(move_req), 32'd0);
    chk("async reset select", 32'(select_loc), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int i = 0; i < 64; i++)
        bd[i] = ($urandom_range(0, 9) < 4) ? {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0)} : 3'b0;
      serialized_board = ser();
      for (int p = 0; p < 30; p++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: mk = B_SEL;
          9: mk = 5'($urandom_range(1, 31));
          default: mk = 5'b00001 << $urandom_range(0, 3);
        endcase
        model_press(mk);
        press(mk);
        cmp_all($sformatf("rand g%0d p%0d", g, p));
        if (m_mode == 2) begin
          chk("rand from", 32'(move_from), 32'(m_from));
          chk("rand to", 32'(move_to), 32'(m_to));
          chk("rand jump", 32'(move_jump), 32'(m_jump));
          if ($urandom_range(0, 1) == 1) begin
            press(5'($urandom_range(1, 31)));
            cmp_all("rand commit press");
          end
          repeat ($urandom_range(0, 5)) @(negedge clk);
          move_ack = 1'b1;
          @(negedge clk);
          move_ack = 1'b0;
          finish_move();
          cmp_all("rand ack");
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
